// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell and a registered running borrow.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one result bit per clock, WIDTH clocks in total
// DONE  | diff/borrow just updated; done pulses for one cycle
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // One spare bit keeps the counter from wrapping when WIDTH is a power of two
  // (and gives it a legal width when WIDTH = 1).
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             d_bit;
  logic             br_nx;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    br_nx = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);
  end

  // Next-state and datapath update; busy/done are decoded from the next state
  // so they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          sd_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sd_d            = sd_q >> 1;
        sd_d[WIDTH-1]   = d_bit;
        sa_d            = sa_q >> 1;
        sb_d            = sb_q >> 1;
        br_d            = br_nx;
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = sd_d;
          borrow_d = br_nx;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset clears everything including results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor: computes a - b - bin over WIDTH clock cycles, LSB first.
- Uses one full-subtractor bit cell per cycle plus a registered borrow, instead of a WIDTH-wide ripple-borrow chain.
- Sits downstream of the full-subtractor cell as its sequential consumer.
- Used where area matters more than latency, e.g. low-rate counters or comparators.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin a subtraction; honoured only in IDLE
- a  input  WIDTH  minuend; sampled on the accepted start edge
- b  input  WIDTH  subtrahend; sampled on the accepted start edge
- bin  input  1  borrow-in; sampled on the accepted start edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when diff and borrow become valid
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH; held until the next completion
- borrow  output  1  final borrow-out (1 when a < b + bin); held with diff

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; busy = 0, done = 0, diff = 0, borrow = 0.
  - Internal shift registers, bit counter and running borrow are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - Leaves IDLE when start = 1 at a clock edge.
  - On that edge: load a into shift register sa, b into sb, bin into running borrow br; clear counter cnt; go to RUN.
  - If start = 0, stay in IDLE.
- RUN, one bit per clock:
  - d = sa[0] ^ sb[0] ^ br.
  - br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br).
  - d shifts into the MSB of the accumulator sd; sd, sa and sb shift right by one; cnt increments.
  - On the edge that processes bit WIDTH-1: load diff with the final accumulator value (the last d included), load borrow with br_next, go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start is accepted at edge 0; done is high during the cycle after edge WIDTH.
  - busy is high for exactly WIDTH cycles.
  - Throughput is one operation per WIDTH+2 cycles when start is held high.
- start in RUN or DONE is ignored; there is no queueing. a, b and bin may change freely after the accepted edge.
- diff and borrow change only on the completion edge and stay stable from done until the next completion. They are not updated during RUN.
- Reset during RUN or DONE aborts the operation: no done pulse, and diff/borrow read 0.
- WIDTH = 1: a single RUN cycle; cnt must be sized at least clog2(WIDTH) + 1 bits to avoid wrap errors.
- busy and done are never high in the same cycle.
- Arithmetic reference model: {borrow, diff} = ({1'b0, a} - {1'b0, b} - bin), taken as a (WIDTH+1)-bit two's-complement result; borrow is its sign bit.

Test Plan:
- WIDTH=8; a=100, b=37, bin=0, start pulsed once -> busy high for 8 cycles; done one cycle after that; diff=63, borrow=0; diff holds until the next op.
- a=0, b=1, bin=0 -> diff=8'hFF, borrow=1. Then a=5, b=5, bin=1 -> diff=8'hFF, borrow=1. Then a=8'hFF, b=8'hFF, bin=0 -> diff=0, borrow=0.
- start held high continuously with a=200, b=55 -> a done pulse every 10 cycles, diff=145 each time. Changing a/b mid-RUN does not affect the result in flight.
- Start op a=9, b=3; assert rst in the 4th RUN cycle -> busy, done, diff and borrow go to 0 immediately with no done pulse. Release rst, run a=9, b=3 -> diff=6, borrow=0.
- Random regression, 2000 ops per config, WIDTH in {1, 4, 8, 16} with random bin, checked against the reference model. For WIDTH=1, all 8 combinations of (a, b, bin) are checked against the full-subtractor truth table.
